chip8_reg_dma: RTL and testbench

CHIP8_REG_DMA -- requirements
Module: chip8_reg_dma

---
 rtl/chip8_pkg.sv | 17 +
 rtl/chip8_lat_pipe.sv | 46 ++++
 rtl/chip8_reg_dma.sv | 135 +++++++++++++
 tb/tb_chip8_reg_dma.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 Fx55/Fx65 register/RAM block mover.
package chip8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    localparam logic DIR_LOAD  = 1'b0;
    localparam logic DIR_STORE = 1'b1;

    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 4;

endpackage

// File: rtl/chip8_lat_pipe.sv
// Delay line carrying a valid bit and register index alongside outstanding RAM reads.
module chip8_lat_pipe
    import chip8_pkg::*;
#(
    parameter int LAT   = RAM_LAT_MIN,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx,
    output logic             pend
);

    logic [LAT-1:0]            vld_pipe_q;
    logic [LAT-1:0][IDX_W-1:0] idx_pipe_q;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            vld_pipe_q <= '0;
            idx_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= in_vld;
            idx_pipe_q[0] <= in_idx;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                idx_pipe_q[i] <= idx_pipe_q[i-1];
            end
        end
    end

    assign out_vld = vld_pipe_q[LAT-1];
    assign out_idx = idx_pipe_q[LAT-1];

    // pend: reads still in flight behind the one being written back this cycle
    generate
        if (LAT > 1) begin : g_pend
            assign pend = |vld_pipe_q[LAT-2:0];
        end else begin : g_nopend
            assign pend = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/chip8_reg_dma.sv
// CHIP-8 Fx55/Fx65 engine: moves V0..Vx to/from RAM at I.
// Define CHIP8_I_INCR_EN for the COSMAC behaviour where I advances to I+x+1 on completion.
module chip8_reg_dma
    import chip8_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 12,
    parameter int NREG    = 16,
    parameter int IDX_W   = (NREG > 1) ? $clog2(NREG) : 1,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              start,
    input  logic              dir,
    input  logic [IDX_W-1:0]  last,
    input  logic [ADDR_W-1:0] base,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  reg_idx,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              reg_we,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              i_upd,
    output logic [ADDR_W-1:0] i_next
);

    localparam int LAT = (RAM_LAT < RAM_LAT_MIN) ? RAM_LAT_MIN :
                         (RAM_LAT > RAM_LAT_MAX) ? RAM_LAT_MAX : RAM_LAT;
    localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(NREG - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  k_q, k_d, last_q, last_d, last_clamp;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              dir_q, dir_d, start_q;
    logic              accept, push, pend, pipe_vld;
    logic [IDX_W-1:0]  pipe_idx;

    // Only a fresh rising edge of start counts, so a held start cannot retrigger.
    assign accept     = start & ~start_q & (state_q == IDLE);
    assign last_clamp = (32'(last) >= NREG) ? LAST_MAX : last;
    assign push       = (state_q == XFER) && (dir_q == DIR_LOAD);

    chip8_lat_pipe #(.LAT(LAT), .IDX_W(IDX_W)) u_pipe (
        .clk     (clk),
        .res_n   (res_n),
        .in_vld  (push),
        .in_idx  (k_q),
        .out_vld (pipe_vld),
        .out_idx (pipe_idx),
        .pend    (pend)
    );

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            last_q  <= '0;
            base_q  <= '0;
            dir_q   <= DIR_LOAD;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            last_q  <= last_d;
            base_q  <= base_d;
            dir_q   <= dir_d;
            start_q <= start;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        last_d  = last_q;
        base_d  = base_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dir_d   = dir;
                    last_d  = last_clamp;
                    base_d  = base;
                    k_d     = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                k_d = k_q + IDX_W'(1);
                if (k_q == last_q) begin
                    k_d     = '0;
                    state_d = (dir_q == DIR_STORE) ? FIN : DRAIN;
                end
            end
            DRAIN:   if (!pend) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == FIN);
        ram_en    = 1'b0;
        ram_wr    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        reg_we    = pipe_vld;
        reg_idx   = pipe_vld ? pipe_idx : '0;
        reg_wdata = pipe_vld ? ram_rdata : '0;
        if (state_q == XFER) begin
            ram_en   = 1'b1;
            ram_wr   = dir_q;
            ram_addr = base_q + ADDR_W'(k_q);
            if (dir_q == DIR_STORE) begin
                reg_idx   = k_q;
                ram_wdata = reg_rdata;
            end
        end
    end

`ifdef CHIP8_I_INCR_EN
    assign i_upd  = done;
    assign i_next = done ? (base_q + ADDR_W'(last_q) + ADDR_W'(1)) : base_q;
`else
    assign i_upd  = 1'b0;
    assign i_next = base_q;
`endif

endmodule

// File: tb/tb_chip8_reg_dma.sv
// Directed bench for chip8_reg_dma with a register-file and latency-RAM model.
module tb_chip8_reg_dma;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        res_n, start, dir;
    logic [3:0]  last;
    logic [11:0] base;
    logic        busy, done, reg_we, ram_en, ram_wr, i_upd;
    logic [3:0]  reg_idx;
    logic [7:0]  reg_rdata, reg_wdata, ram_wdata, ram_rdata;
    logic [11:0] ram_addr, i_next;

    int checks = 0;
    int failures = 0;

    logic [7:0] regs [16];
    logic [7:0] mem [4096];
    logic [7:0] rd_pipe [LAT];
    logic       pr_we = 1'b0, pm_we = 1'b0;
    logic [3:0] pr_idx = '0;
    logic [11:0] pm_addr = '0;
    logic [7:0] pr_data = '0, pm_data = '0;

    always #5 clk = ~clk;

    chip8_reg_dma #(.DATA_W(8), .ADDR_W(12), .NREG(16), .RAM_LAT(LAT)) dut (
        .clk(clk), .res_n(res_n), .start(start), .dir(dir), .last(last), .base(base),
        .busy(busy), .done(done), .reg_idx(reg_idx), .reg_rdata(reg_rdata),
        .reg_we(reg_we), .reg_wdata(reg_wdata), .ram_en(ram_en), .ram_wr(ram_wr),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .i_upd(i_upd), .i_next(i_next)
    );

    assign reg_rdata = regs[reg_idx];
    assign ram_rdata = rd_pipe[LAT-1];

    always @(posedge clk) begin
        if (reg_we) regs[reg_idx] <= reg_wdata;
        else if (pr_we) regs[pr_idx] <= pr_data;
        if (ram_en && ram_wr) mem[ram_addr] <= ram_wdata;
        else if (pm_we) mem[pm_addr] <= pm_data;
        rd_pipe[0] <= (ram_en && !ram_wr) ? mem[ram_addr] : 8'h00;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke_reg(input logic [3:0] idx, input logic [7:0] d);
        pr_we = 1'b1; pr_idx = idx; pr_data = d;
        tick();
        pr_we = 1'b0;
    endtask

    task automatic poke_mem(input logic [11:0] a, input logic [7:0] d);
        pm_we = 1'b1; pm_addr = a; pm_data = d;
        tick();
        pm_we = 1'b0;
    endtask

    task automatic test_reset();
        res_n = 1'b0; start = 1'b0; dir = 1'b0; last = '0; base = '0;
        tick(); tick();
        checks++;
        if ({busy, done, reg_we, ram_en, ram_wr, i_upd} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, reg_we, ram_en, ram_wr, i_upd});
        end
        checks++;
        if (ram_addr !== 12'h000 || ram_wdata !== 8'h00 || i_next !== 12'h000) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h inext=%h exp=0", ram_addr, ram_wdata, i_next);
        end
        res_n = 1'b1;
        tick();
    endtask

    task automatic test_store();
        logic [7:0] exp [4];
        exp = '{8'd11, 8'd22, 8'd33, 8'd44};
        for (int i = 0; i < 4; i++) poke_reg(4'(i), exp[i]);
        start = 1'b1; dir = 1'b1; last = 4'd3; base = 12'h300;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL store_busy_c0 got=%b exp=0", busy); end
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0;
            if (c <= 4) begin
                checks++;
                if (ram_en !== 1'b1 || ram_wr !== 1'b1 || busy !== 1'b1 ||
                    ram_addr !== 12'(12'h300 + c - 1) || ram_wdata !== exp[c-1]) begin
                    failures++;
                    $display("FAIL store_wr c=%0d got en=%b wr=%b addr=%h d=%h exp addr=%h d=%h",
                             c, ram_en, ram_wr, ram_addr, ram_wdata, 12'(12'h300 + c - 1), exp[c-1]);
                end
            end else begin
                checks++;
                if (ram_en !== 1'b0 || ram_wr !== 1'b0) begin
                    failures++; $display("FAIL store_idle_ram c=%0d got en=%b wr=%b exp=0", c, ram_en, ram_wr);
                end
            end
            checks++;
            if (done !== (c == 5)) begin
                failures++; $display("FAIL store_done c=%0d got=%b exp=%b", c, done, (c == 5));
            end
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL store_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_wrap();
        logic [11:0] ea [3];
        ea = '{12'hFFE, 12'hFFF, 12'h000};
        start = 1'b1; dir = 1'b1; last = 4'd2; base = 12'hFFE;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
            if (c <= 3) begin
                checks++;
                if (ram_en !== 1'b1 || ram_addr !== ea[c-1]) begin
                    failures++;
                    $display("FAIL wrap_addr c=%0d got=%h exp=%h", c, ram_addr, ea[c-1]);
                end
            end
        end
        checks++;
        if (mem[12'h000] !== 8'd33) begin
            failures++; $display("FAIL wrap_mem got=%h exp=%h", mem[12'h000], 8'd33);
        end
        tick();
    endtask

    task automatic test_load();
        int nw, nd, late;
        for (int i = 0; i < 16; i++) poke_mem(12'(12'h200 + i), 8'(8'hA0 + i));
        nw = 0; nd = 0; late = 0;
        start = 1'b1; dir = 1'b0; last = 4'd15; base = 12'h200;
        for (int c = 1; c <= 26; c++) begin
            tick();
            start = 1'b0;
            if (reg_we === 1'b1) begin
                checks++;
                if (reg_idx !== 4'(nw) || reg_wdata !== 8'(8'hA0 + nw) || c != nw + 4) begin
                    failures++;
                    $display("FAIL load_wr c=%0d got idx=%0d d=%h exp idx=%0d d=%h c=%0d",
                             c, reg_idx, reg_wdata, nw, 8'(8'hA0 + nw), nw + 4);
                end
                nw++;
                if (c > 20) late++;
            end
            if (done === 1'b1) begin
                checks++;
                if (c != 20) begin failures++; $display("FAIL load_done_cycle got=%0d exp=20", c); end
                nd++;
            end
        end
        checks++;
        if (nw != 16 || nd != 1 || late != 0) begin
            failures++; $display("FAIL load_counts got wr=%0d done=%0d late=%0d exp 16/1/0", nw, nd, late);
        end
    endtask

    task automatic test_reset_mid();
        int nwe, nbusy;
        start = 1'b1; dir = 1'b0; last = 4'd15; base = 12'h200;
        tick(); start = 1'b0;
        tick(); tick();
        res_n = 1'b0;
        tick();
        res_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || reg_we !== 1'b0 || ram_en !== 1'b0) begin
            failures++; $display("FAIL rst_mid_now got busy=%b we=%b en=%b exp=0", busy, reg_we, ram_en);
        end
        nwe = 0; nbusy = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (reg_we !== 1'b0 || ram_en !== 1'b0) nwe++;
            if (busy !== 1'b0) nbusy++;
        end
        checks++;
        if (nwe != 0 || nbusy != 0) begin
            failures++; $display("FAIL rst_mid_quiet got writes=%0d busy=%0d exp 0/0", nwe, nbusy);
        end
        start = 1'b1; dir = 1'b1; last = 4'd0; base = 12'h100;
        tick(); start = 1'b0;
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 12'h100 || ram_wdata !== 8'hA0) begin
            failures++; $display("FAIL rst_mid_restart got en=%b addr=%h d=%h exp 1/100/a0", ram_en, ram_addr, ram_wdata);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL rst_mid_done got=%b exp=1", done); end
        tick();
    endtask

    task automatic test_start_held();
        int nd, nen;
        nd = 0; nen = 0;
        start = 1'b1; dir = 1'b1; last = 4'd0; base = 12'h120;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 10) start = 1'b0;
            if (done === 1'b1) nd++;
            if (ram_en === 1'b1) nen++;
        end
        checks++;
        if (nd != 1 || nen != 1) begin
            failures++; $display("FAIL start_held got done=%0d xfers=%0d exp 1/1", nd, nen);
        end
    endtask

    task automatic test_i_incr();
        int nupd;
        logic [11:0] inext_at_done;
        int done_c;
        nupd = 0; done_c = 0; inext_at_done = '0;
        start = 1'b1; dir = 1'b1; last = 4'd5; base = 12'h400;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            if (i_upd === 1'b1) nupd++;
            if (done === 1'b1) begin done_c = c; inext_at_done = i_next; end
        end
        checks++;
        if (done_c != 7) begin failures++; $display("FAIL iincr_done_cycle got=%0d exp=7", done_c); end
`ifdef CHIP8_I_INCR_EN
        checks++;
        if (nupd != 1 || inext_at_done !== 12'h406) begin
            failures++; $display("FAIL iincr_on got upd=%0d inext=%h exp 1/406", nupd, inext_at_done);
        end
`else
        checks++;
        if (nupd != 0 || inext_at_done !== 12'h400) begin
            failures++; $display("FAIL iincr_off got upd=%0d inext=%h exp 0/400", nupd, inext_at_done);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_store();
        test_wrap();
        test_load();
        test_reset_mid();
        test_start_held();
        test_i_incr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
